apb_regbank_slave: RTL and testbench

Parametrised APB4 completer with an internal register bank, programmable wait states, byte strobes and error response. It is the next generation of the single-cycle APB slave front end: it owns its storage, so no external rd_data/wr_data path is needed. It sits on the peripheral APB segment behind the bridge and exposes every register to the local block through a flattened output bus and per-register write strobes.

---
 rtl/apb_regbank_slave.sv | 98 +++++++++
 tb/tb_apb_regbank_slave.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB4 completer owning a register bank, with wait states, byte strobes and error response.
// Ports: pclk/preset (async active-high) clock and reset; paddr/psel/penable/pwrite/pwdata/pstrb APB request;
// prdata/pready/pslverr APB response; reg_q flattened register contents; reg_wr per-register write pulse.
module apb_regbank_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [ADDRESS_WIDTH-1:0]       paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB = $clog2(STRB_W);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] LSB_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);
  localparam logic [IDX_W:0] REG_CNT = (IDX_W + 1)'(NUM_REGS);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic err_q, err_d, write_q, write_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic [IDX_W-1:0] idx;
  logic dec_err, complete, unused_penable;
  // penable carries no information here: the FSM tracks setup vs access itself
  assign unused_penable = penable;
  assign idx = paddr[LSB +: IDX_W];
  assign dec_err = ({1'b0, idx} >= REG_CNT) || |(paddr & LSB_MASK) || |(paddr >> (LSB + IDX_W));
  assign complete = state_q == ACCESS && psel && wcnt_q == '0;
  assign pready = complete;
  assign pslverr = complete && err_q;
  assign prdata = complete && !write_q && !err_q ? mem_q[idx_q] : '0;
  assign reg_wr = reg_wr_q;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    idx_d = idx_q;
    err_d = err_q;
    write_d = write_q;
    mem_d = mem_q;
    reg_wr_d = '0;
    if (state_q == IDLE) begin
      if (psel) begin
        state_d = ACCESS;
        wcnt_d = 4'(WAIT_STATES);
        idx_d = idx;
        err_d = dec_err;
        write_d = pwrite;
      end
    end else if (!psel || complete) begin
      state_d = IDLE;
    end else begin
      wcnt_d = wcnt_q - 4'd1;
    end
    if (complete && write_q && !err_q) begin
      for (int b = 0; b < STRB_W; b++)
        if (pstrb[b]) mem_d[idx_q][8*b +: 8] = pwdata[8*b +: 8];
      reg_wr_d[idx_q] = 1'b1;
    end
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      write_q <= 1'b0;
      reg_wr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      idx_q <= idx_d;
      err_q <= err_d;
      write_q <= write_d;
      reg_wr_q <= reg_wr_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb_apb_regbank_slave: three instances (0, 2 and 3 wait states) checked against an array model.
module tb_apb_regbank_slave;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam logic [31:0] RV = 32'hA5A5_0F0F;
  logic pclk = 1'b0;
  logic preset = 1'b0;
  logic [31:0] paddr, pwdata;
  logic pwrite, penable;
  logic [3:0] pstrb;
  logic [2:0] psel;
  logic [31:0] prdata [3];
  logic [2:0] pready, pslverr;
  logic [NR*DW-1:0] reg_q [3];
  logic [NR-1:0] reg_wr [3];
  logic [31:0] model [3][NR];
  int errors = 0;
  int checks = 0;
  always #5 pclk = ~pclk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    apb_regbank_slave #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(32), .NUM_REGS(NR),
      .WAIT_STATES(k == 0 ? 0 : k + 1), .RESET_VALUE(RV)
    ) u_dut (
      .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel[k]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[k]),
      .pready(pready[k]), .pslverr(pslverr[k]), .reg_q(reg_q[k]), .reg_wr(reg_wr[k])
    );
  end
  function automatic int ws(input int k);
    return k == 0 ? 0 : k + 1;
  endfunction
  function automatic logic [NR*DW-1:0] flat(input int k);
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[k][i];
    return f;
  endfunction
  task automatic reset_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++) model[k][i] = RV;
  endtask
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rd, output logic e);
    int waits;
    waits = 0;
    @(negedge pclk);
    psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    while (pready[k] !== 1'b1 && waits <= 20) begin
      chk("wait_prdata", 256'(prdata[k]), 256'(0));
      chk("wait_pslverr", 256'(pslverr[k]), 256'(0));
      chk("wait_reg_q", reg_q[k], flat(k));
      waits++;
      @(negedge pclk);
      #1;
    end
    chk("latency", 256'(waits), 256'(ws(k)));
    rd = prdata[k];
    e = pslverr[k];
    @(posedge pclk);
    #1;
    psel[k] = 1'b0; penable = 1'b0;
  endtask
  task automatic op(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb);
    logic [31:0] rd;
    logic e, ex_err;
    int idx;
    logic [NR-1:0] ewr;
    ex_err = (addr % 4 != 0) || (addr / 4 >= NR);
    idx = ex_err ? 0 : int'(addr / 4);
    ewr = '0;
    xfer(k, wr, addr, data, strb, rd, e);
    chk("pslverr", 256'(e), 256'(ex_err));
    if (!wr) chk("prdata", 256'(rd), 256'(ex_err ? 32'h0 : model[k][idx]));
    if (wr && !ex_err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[k][idx][8*b +: 8] = data[8*b +: 8];
      ewr[idx] = 1'b1;
    end
    chk("reg_q", reg_q[k], flat(k));
    chk("reg_wr", 256'(reg_wr[k]), 256'(ewr));
  endtask
  initial begin
    logic [31:0] a;
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    reset_model();
    #3 preset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_reg_q", reg_q[k], flat(k));
      chk("rst_pready", 256'(pready[k]), 256'(0));
      chk("rst_pslverr", 256'(pslverr[k]), 256'(0));
      chk("rst_reg_wr", 256'(reg_wr[k]), 256'(0));
    end
    @(negedge pclk) preset = 1'b0;
    op(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF);
    chk("wr_lit", 256'(reg_q[0][95:64]), 256'(32'hDEAD_BEEF));
    chk("wr_pulse", 256'(reg_wr[0]), 256'(8'b0000_0100));
    @(posedge pclk);
    #1;
    chk("wr_pulse_end", 256'(reg_wr[0]), 256'(0));
    op(0, 1'b0, 32'h08, 32'h0, 4'h0);
    op(0, 1'b1, 32'h04, 32'h1122_3344, 4'hF);
    op(0, 1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101);
    chk("strb_lit", 256'(reg_q[0][63:32]), 256'(32'h11BB_33DD));
    op(0, 1'b0, 32'h04, 32'h0, 4'hF);
    op(0, 1'b1, 32'h0C, 32'hFFFF_FFFF, 4'h0);
    op(0, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    op(0, 1'b1, 32'h02, 32'h1234_5678, 4'hF);
    op(0, 1'b1, 32'h1000_0000, 32'h1234_5678, 4'hF);
    op(0, 1'b0, 32'h20, 32'h0, 4'h0);
    op(2, 1'b1, 32'h1C, 32'h1234_5678, 4'hF);
    op(2, 1'b0, 32'h1C, 32'h0, 4'h0);
    @(negedge pclk);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    chk("abort_pready", 256'(pready[1]), 256'(0));
    #1;
    psel[1] = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      chk("abort_pready_low", 256'(pready[1]), 256'(0));
    end
    chk("abort_reg_q", reg_q[1], flat(1));
    chk("abort_reg_wr", 256'(reg_wr[1]), 256'(0));
    op(1, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF);
    @(negedge pclk);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5555_5555; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk);
    #2 preset = 1'b1;
    reset_model();
    #1;
    chk("rst_mid_pready", 256'(pready[1]), 256'(0));
    for (int k = 0; k < 3; k++) chk("rst_mid_reg_q", reg_q[k], flat(k));
    @(negedge pclk);
    preset = 1'b0; psel[1] = 1'b0; penable = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_mid_no_commit", reg_q[1], flat(1));
    op(1, 1'b1, 32'h04, 32'h55AA_55AA, 4'hF);
    op(1, 1'b0, 32'h04, 32'h0, 4'h0);
    repeat (60) begin
      int k;
      int r;
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      a = r < 8 ? 32'(r * 4) : r == 8 ? 32'($urandom_range(8, 15) * 4) : $urandom;
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      op(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
